// File: rtl/sram_1rw_arbiter_pkg.sv
// Shared definitions for the single-port SRAM arbiter: tag width helpers
// and the fixed read latency of the macro path.
package sram_ctrl_pkg;

  // Posedges from request accept to capture of dout0 into the response register.
  localparam int RD_LATENCY = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sram_1rw_arbiter_if.sv
// Client-side bus of the arbiter: per-requester valid/ready request
// channel plus the shared tagged read-response channel.
interface sram_1rw_arbiter_if
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
);
  localparam int ID_WIDTH = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  // Client logic drives requests and consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata
  );

  // The arbiter accepts requests and produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata
  );
endinterface

// File: rtl/sram_1rw_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves past the winner only when the grant is taken.
module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                   clk0,
  input  logic                   rst0_n,
  input  logic [N-1:0]           i_req,
  input  logic                   i_advance,
  output logic [N-1:0]           o_grant,
  output logic [id_width(N)-1:0] o_win
);
  localparam int PW = id_width(N);

  logic [PW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [PW-1:0] w_win;

  // Scan from the farthest offset back to the pointer so the closest requester wins.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(r_ptr) + k) % N]) begin
        w_grant = '0;
        w_grant[(int'(r_ptr) + k) % N] = 1'b1;
        w_win = PW'((int'(r_ptr) + k) % N);
      end
    end
  end

  // Pointer moves to the requester after the one just accepted.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
    end
  end

  assign o_grant = w_grant;
  assign o_win   = w_win;
endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one 1RW SRAM macro port among NUM_REQ requesters. Macro controls
// are registered at accept; read tags ride a short pipeline alongside the
// macro access and meet dout0 in the response register.
module sram_1rw_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  sram_1rw_arbiter_if.slave     bus,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);
  localparam int ID_WIDTH = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_win;
  logic                  w_acc;
  logic                  w_rd_acc;
  logic [RD_LATENCY-1:0] r_vld_p;
  logic [ID_WIDTH-1:0]   r_id_p [RD_LATENCY];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .i_req     (bus.req_valid),
    .i_advance (w_acc),
    .o_grant   (w_grant),
    .o_win     (w_win)
  );

  // Nothing is granted while reset is held.
  assign bus.req_ready = rst0_n ? w_grant : '0;
  assign w_acc         = |bus.req_ready;
  assign w_rd_acc      = w_acc & ~bus.req_we[w_win];

  // Issue stage: present the accepted request to the macro; idle keeps addr/din.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else if (w_acc) begin
      csb0  <= 1'b0;
      web0  <= ~bus.req_we[w_win];
      addr0 <= bus.req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
      din0  <= bus.req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
    end
  end

  // Read tag pipeline: stage 0 at accept, last stage lines up with valid dout0.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_vld_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_id_p[i] <= '0;
    end else begin
      r_vld_p   <= {r_vld_p[RD_LATENCY-2:0], w_rd_acc};
      r_id_p[0] <= w_win;
      for (int i = 1; i < RD_LATENCY; i++) r_id_p[i] <= r_id_p[i-1];
    end
  end

  // Response stage: one-cycle pulse carrying the macro read data and its owner.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= r_vld_p[RD_LATENCY-1];
      if (r_vld_p[RD_LATENCY-1]) begin
        bus.rsp_id    <= r_id_p[RD_LATENCY-1];
        bus.rsp_rdata <= dout0;
      end
    end
  end
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter: behavioural macro model, in-order scoreboard
// with a reference memory, table-driven vectors and corner sequences.
module tb_sram_1rw_arbiter;
  import sram_ctrl_pkg::*;

  localparam int N  = 2;
  localparam int DW = 2;
  localparam int AW = 4;

  logic clk0 = 1'b0;
  logic rst0_n = 1'b1;
  always #5 clk0 = ~clk0;

  sram_1rw_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sram_1rw_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0, dout0;
  logic          csb0_3, web0_3;
  logic [AW-1:0] addr0_3;
  logic [DW-1:0] din0_3;
  logic [DW-1:0] dout0_3 = '0;

  sram_1rw_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk0(clk0), .rst0_n(rst0_n), .bus(bus),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  sram_1rw_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut3 (
    .clk0(clk0), .rst0_n(rst0_n), .bus(bus3),
    .csb0(csb0_3), .web0(web0_3), .addr0(addr0_3), .din0(din0_3), .dout0(dout0_3)
  );

  // ---------------- macro model: capture at posedge, access at negedge
  logic [DW-1:0] mem [16];
  logic          m_en = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  always @(posedge clk0) begin
    m_en   <= ~csb0;
    m_we   <= ~web0;
    m_addr <= addr0;
    m_din  <= din0;
  end

  always @(negedge clk0) begin
    if (m_en === 1'b1) begin
      if (m_we) mem[m_addr] <= m_din;
      else      dout0       <= mem[m_addr];
    end
  end

  // ---------------- counters and check helper
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk0) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: arbitration rule + ordered memory
  typedef struct { int due; logic id; logic [DW-1:0] d; } exp_t;
  typedef struct { int c; logic id; logic [DW-1:0] d; } log_t;
  exp_t          exp_q [$];
  log_t          rsp_log [$];
  logic [DW-1:0] ref_mem [16];
  int            ptr_m = 0;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
    return '0;
  endfunction

  always @(negedge clk0) begin
    logic [N-1:0] g;
    if (!rst0_n) begin
      exp_q.delete();
      ptr_m = 0;
    end else begin
      g = model_grant(bus.req_valid, ptr_m);
      chk("mon_grant", 32'(bus.req_ready), 32'(g));
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("mon_missing_rsp", 32'(0), 32'(1));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("mon_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        chk("mon_rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
        chk("mon_rsp_data", 32'(bus.rsp_rdata), 32'(exp_q[0].d));
        void'(exp_q.pop_front());
      end else begin
        chk("mon_no_rsp", 32'(bus.rsp_valid), 32'(0));
      end
      if (bus.rsp_valid === 1'b1) rsp_log.push_back('{cyc, bus.rsp_id, bus.rsp_rdata});
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          if (bus.req_we[i])
            ref_mem[bus.req_addr[i*AW +: AW]] = bus.req_wdata[i*DW +: DW];
          else
            exp_q.push_back('{cyc + RD_LATENCY + 1, 1'(i), ref_mem[bus.req_addr[i*AW +: AW]]});
          ptr_m = (i + 1) % N;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [1:0] d0, input logic [1:0] d1);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  task automatic next();
    @(posedge clk0);
    #1;
  endtask

  typedef struct {
    logic [1:0] valid; logic [1:0] we; logic [3:0] a0; logic [3:0] a1;
    logic [1:0] d0; logic [1:0] d1; logic [1:0] ready;
    logic rv; logic id; logic [1:0] rd;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pv, pwe, acc;
    logic [3:0] pa [2];
    logic [1:0] pd [2];

    for (int i = 0; i < 16; i++) begin
      mem[i]     <= '0;
      ref_mem[i]  = '0;
    end
    mem[1] <= 2'b01; ref_mem[1] = 2'b01;
    mem[2] <= 2'b11; ref_mem[2] = 2'b11;
    drive(2'b11, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00);
    bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;

    // ---- reset state
    #1 rst0_n = 1'b0;
    #2;
    chk("rst_csb0", 32'(csb0), 32'(1));
    chk("rst_web0", 32'(web0), 32'(1));
    chk("rst_addr0", 32'(addr0), 32'(0));
    chk("rst_din0", 32'(din0), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
    chk("rst_ready", 32'(bus.req_ready), 32'(0));
    drive(2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00);
    @(posedge clk0); @(posedge clk0); #1;
    rst0_n = 1'b1;

    // ---- table: write/read hazard, round-robin alternation, idle gap
    tbl[0]  = '{2'b01, 2'b01, 4'h3, 4'h0, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 4'h3, 4'h0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00};
    tbl[2]  = '{2'b11, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00};
    tbl[3]  = '{2'b11, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 2'b10};
    tbl[5]  = '{2'b11, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 2'b11};
    tbl[6]  = '{2'b00, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
    tbl[7]  = '{2'b01, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 2'b11};
    tbl[8]  = '{2'b00, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
    tbl[9]  = '{2'b00, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[10] = '{2'b00, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].valid, tbl[r].we, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
      @(negedge clk0);
      chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
      chk($sformatf("tbl%0d_rsp_valid", r), 32'(bus.rsp_valid), 32'(tbl[r].rv));
      if (tbl[r].rv) begin
        chk($sformatf("tbl%0d_rsp_id", r), 32'(bus.rsp_id), 32'(tbl[r].id));
        chk($sformatf("tbl%0d_rsp_data", r), 32'(bus.rsp_rdata), 32'(tbl[r].rd));
      end
      next();
    end

    // ---- idle/stall: macro deselected, no responses, pointer held at 1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk0);
      chk("idle_csb0", 32'(csb0), 32'(1));
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'(0));
      next();
    end
    drive(2'b11, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00);
    @(negedge clk0);
    chk("idle_ptr_held", 32'(bus.req_ready), 32'(2'b10));
    next();
    drive(2'b01, 2'b00, 4'h1, 4'h2, 2'b00, 2'b00);
    @(negedge clk0);
    chk("idle_second_grant", 32'(bus.req_ready), 32'(2'b01));
    next();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00);
    repeat (4) next();

    // ---- full sweep: req1 writes k[1:0] everywhere, req0 reads back
    for (int k = 0; k < 16; k++) begin
      drive(2'b10, 2'b10, 4'h0, 4'(k), 2'b00, 2'(k));
      next();
    end
    rsp_log.delete();
    for (int k = 0; k < 16; k++) begin
      drive(2'b01, 2'b00, 4'(k), 4'h0, 2'b00, 2'b00);
      next();
    end
    drive(2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00);
    repeat (5) next();
    chk("sweep_count", 32'(rsp_log.size()), 32'(16));
    for (int k = 0; k < 16 && k < rsp_log.size(); k++) begin
      chk($sformatf("sweep%0d_data", k), 32'(rsp_log[k].d), 32'(k % 4));
      chk($sformatf("sweep%0d_id", k), 32'(rsp_log[k].id), 32'(0));
      chk($sformatf("sweep%0d_cycle", k), 32'(rsp_log[k].c - rsp_log[0].c), 32'(k));
    end

    // ---- randomized traffic, requests held until accepted
    pv = '0; pwe = '0;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 60) begin
          pv[i]  = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i]  = 4'($urandom_range(0, 15));
          pd[i]  = 2'($urandom_range(0, 3));
        end
      end
      drive(pv, pwe, pa[0], pa[1], pd[0], pd[1]);
      @(negedge clk0);
      acc = bus.req_ready & bus.req_valid;
      next();
      pv = pv & ~acc;
    end
    drive(2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00);
    repeat (5) next();
    chk("rand_drained", 32'(exp_q.size()), 32'(0));

    // ---- reset mid-stream with reads in flight
    drive(2'b11, 2'b00, 4'h5, 4'h6, 2'b00, 2'b00);
    repeat (3) next();
    #1 rst0_n = 1'b0;
    drive(2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00);
    #1;
    chk("midrst_csb0", 32'(csb0), 32'(1));
    chk("midrst_web0", 32'(web0), 32'(1));
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("midrst_ready", 32'(bus.req_ready), 32'(0));
    @(posedge clk0); @(posedge clk0); #1;
    rst0_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk0);
      chk("postrst_no_stale_rsp", 32'(bus.rsp_valid), 32'(0));
      next();
    end

    // ---- wrap-around on the 3-requester instance
    bus3.req_valid = 3'b010;
    @(negedge clk0);
    chk("wrap_setup", 32'(bus3.req_ready), 32'(3'b010));
    next();
    bus3.req_valid = 3'b101;
    @(negedge clk0);
    chk("wrap_grant_req2", 32'(bus3.req_ready), 32'(3'b100));
    next();
    @(negedge clk0);
    chk("wrap_grant_req0", 32'(bus3.req_ready), 32'(3'b001));
    next();
    @(negedge clk0);
    chk("wrap_grant_req2_again", 32'(bus3.req_ready), 32'(3'b100));
    next();
    bus3.req_valid = 3'b000;
    repeat (4) next();
    chk("final_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_1rw_arbiter.md
Name: sram_1rw_arbiter

Overview:
- Shares one 1RW OpenRAM SRAM macro port (clk0, csb0, web0, addr0, din0, dout0) between NUM_REQ requesters.
- Arbitration is round-robin, with a valid/ready request handshake per requester.
- Read data returns on a tagged response channel with fixed latency.
- Sits between client logic and the macro; drives all macro control inputs from registers.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 2, macro word width.
- ADDR_WIDTH, 4, macro address width.
- ID_WIDTH, derived clog2(NUM_REQ) (min 1), response tag width; not overridable.

Ports:
- clk0  in  1  clock; the same clock feeds the macro clk0.
- rst0_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  1  read data valid (one cycle, no backpressure).
- rsp_id  out  ID_WIDTH  index of the requester owning rsp_rdata.
- rsp_rdata  out  DATA_WIDTH  read data.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset values (asynchronous, while rst0_n=0):
  - csb0=1, web0=1, addr0=0, din0=0.
  - rsp_valid=0, rsp_id=0, rsp_rdata=0.
  - rr pointer=0, pipeline valids=0.
  - req_ready=0 during reset.
- Reset mid-operation:
  - In-flight reads are discarded and no rsp_valid is produced for them.
  - A write already captured by the macro may still complete. This is acceptable.
- Grant:
  - Combinational req_ready: at most one bit set per cycle.
  - The winner is the first requester with req_valid set, scanning from rr pointer upward with wrap-around.
  - Accept happens at posedge T0 when req_valid[i] && req_ready[i].
  - On accept, rr pointer becomes (i+1) mod NUM_REQ. With no accept, the pointer holds.
- Issue stage (registered on T0):
  - csb0=0, web0=~req_we[i], addr0/din0 = slice i.
  - With no accept: csb0=1, web0=1; addr0/din0 hold their previous values.
  - The macro captures these at T1, then reads or writes on the negedge after T1.
- Read return:
  - A 2-stage tag pipeline (valid, id) advances T0->T1->T2.
  - At T2 the block registers rsp_rdata=dout0, rsp_id=i, rsp_valid=1 for exactly one cycle.
  - Fixed latency: rsp_valid is high in the cycle following T2.
  - Writes produce no response.
- Throughput: one access per cycle. Back-to-back reads give back-to-back responses in issue order.
- Ordering/hazard:
  - A write accepted at T0 followed by a read to the same address accepted at T0+1 returns the new data.
  - The macro writes on the negedge after T1, before the read negedge after T2.
  - No forwarding logic is required.
- req_valid must stay high until accepted.
  - req_we/addr/wdata must be stable while valid and not ready.
  - Dropping valid before accept is legal; the block does not track it.
- DELAY in the macro is below half a clock period. Sampling dout0 on posedge is therefore always valid.

Decomposition:
- Shared package sram_ctrl_pkg:
  - clog2 function.
  - ID_WIDTH derivation.
  - Read latency constant RD_LATENCY=2, in posedges from accept to capture.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N] and advance; output grant[N] one-hot.
  - Holds the rotating pointer, reset to 0 asynchronously on rst0_n.
- The top level contains the issue registers, tag pipeline and response register.

Test Plan:
- Reset: assert rst0_n=0 mid-stream -> csb0=1, web0=1, rsp_valid=0 immediately. After release, no stale rsp_valid appears.
- Single write then read:
  - Stimulus: req0 writes addr=4'h3, data=2'b10 at T0; req0 reads addr=4'h3 at T0+1.
  - Required: rsp_valid with rsp_id=0, rsp_rdata=2'b10, in the cycle after T0+3.
- Round-robin fairness:
  - Stimulus: req0 and req1 both continuously reading addr 1 and 2 (preloaded 2'b01, 2'b11).
  - Required: grants alternate 0,1,0,1; responses alternate id 0/1 with matching data; one response per cycle.
- Wrap-around: NUM_REQ=3, pointer at 2, only req0 and req2 valid -> grant req2, then req0, then req2.
- Full sweep:
  - Stimulus: write addr k = k[1:0] for k = 0..15 from req1, then read all 16 from req0.
  - Required: 16 consecutive rsp_valid cycles with data k[1:0]; rsp_id=0.
- Idle/stall: no req_valid for 5 cycles -> csb0 stays 1, rsp_valid stays 0, pointer unchanged.
